// File: rtl/seg_scan_controller.sv
// seg_scan_controller
//   Scan scheduler for a multiplexed 7-segment display. One shared hex_to_seg
//   decoder serves NUM_DIGITS digits. The controller enables one digit at a time
//   and moves to the next digit at a prescaled rate.
//
//   A new value arrives on a valid/ready port and is held in a pending buffer.
//   It becomes visible only at a frame boundary, so a frame never mixes values.
//   Brightness is set by PWM inside each digit slot. Leading-zero digits can be
//   blanked.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   load_valid   producer offers load_data
//   load_data    packed nibbles, [3:0] = digit 0 (least significant)
//   load_ready   pending buffer empty, a load is accepted this cycle
//   blank_lz     1 = suppress leading zero digits (digit 0 is never blanked)
//   duty         brightness; 0 = off, all-ones = always on
//   digit        one-hot active-high digit enable (registered)
//   nibble       value of the digit being scanned, to hex_to_seg (registered)
//   frame_start  one-cycle pulse in the cycle after every frame boundary
module seg_scan_controller #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DUTY_W     = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  input  logic                    blank_lz,
  input  logic [DUTY_W-1:0]       duty,
  output logic [NUM_DIGITS-1:0]   digit,
  output logic [3:0]              nibble,
  output logic                    frame_start
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  // Width of one PWM step, in clk cycles, inside a digit slot.
  localparam int DUTY_STEP = SCAN_DIV >> DUTY_W;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_reg;
  logic [IDX_W-1:0]        idx_reg;
  logic [4*NUM_DIGITS-1:0] shown_reg;
  logic [4*NUM_DIGITS-1:0] pend_reg;
  logic                    pend_full_reg;

  logic                    tick;
  logic                    frame_end;
  logic                    slot_on;
  logic                    blank;
  logic [31:0]             on_limit;
  logic [NUM_DIGITS-1:0]   hi_zero;
  logic [NUM_DIGITS-1:0]   digit_next;
  logic [3:0]              nib_arr [NUM_DIGITS];

  assign tick       = (cnt_reg == CNT_LAST);
  assign frame_end  = tick && (idx_reg == IDX_LAST);
  assign load_ready = !pend_full_reg;

  // The digit is lit for the first duty*DUTY_STEP cycles of its slot.
  // With duty at all-ones it stays lit for the whole slot.
  assign on_limit = 32'(duty) * 32'(DUTY_STEP);
  assign slot_on  = (&duty) || (32'(cnt_reg) < on_limit);

  // hi_zero[gi]: every shown nibble from gi up to the top digit is zero.
  // Each bit is computed from shown_reg on its own, so there is no ripple chain.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign hi_zero[gi]    = ~|shown_reg[4*NUM_DIGITS-1:4*gi];
    assign nib_arr[gi]    = shown_reg[4*gi +: 4];
    // The compare against idx_reg makes the enable one-hot by construction.
    assign digit_next[gi] = slot_on && !blank && (idx_reg == IDX_W'(gi));
  end

  assign blank = blank_lz && (idx_reg != '0) && hi_zero[idx_reg];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shown_reg     <= '0;
      pend_reg      <= '0;
      pend_full_reg <= 1'b0;
      digit         <= '0;
      nibble        <= '0;
      frame_start   <= 1'b0;
    end else begin
      cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
      if (tick) begin
        idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
      end

      // A commit and a capture cannot happen in the same cycle.
      // A capture needs ready, and ready is low whenever a commit is due.
      if (frame_end && pend_full_reg) begin
        shown_reg     <= pend_reg;
        pend_full_reg <= 1'b0;
      end else if (load_valid && !pend_full_reg) begin
        pend_reg      <= load_data;
        pend_full_reg <= 1'b1;
      end

      // Outputs reflect the slot state before this edge.
      // nibble follows the scan even when the digit is blanked.
      digit       <= digit_next;
      nibble      <= nib_arr[idx_reg];
      frame_start <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_controller.sv
module tb_seg_scan_controller;

  localparam int NUM_DIGITS = 4;
  localparam int SCAN_DIV   = 8;
  localparam int DUTY_W     = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic [15:0] load_data;
  logic        load_ready;
  logic        blank_lz;
  logic [2:0]  duty;
  logic [3:0]  digit;
  logic [3:0]  nibble;
  logic        frame_start;

  int errors = 0;
  int checks = 0;

  seg_scan_controller #(
    .NUM_DIGITS(NUM_DIGITS),
    .SCAN_DIV  (SCAN_DIV),
    .DUTY_W    (DUTY_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .blank_lz   (blank_lz),
    .duty       (duty),
    .digit      (digit),
    .nibble     (nibble),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Reference model of the scan state. It is written directly from the
  // behaviour description.
  int          m_cnt;
  int          m_idx;
  logic [15:0] m_shown;
  logic [15:0] m_pend;
  bit          m_pfull;

  typedef struct {
    logic [3:0] digit;
    logic [3:0] nibble;
    logic       fs;
    logic       ready;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic [15:0] value;
    bit          blank;
    logic [2:0]  duty;
    logic [3:0]  mask;   // digits expected to light up
    int          on;     // lit cycles per lit digit slot
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_idx   = 0;
    m_shown = 16'h0;
    m_pend  = 16'h0;
    m_pfull = 1'b0;
  endtask

  // One clock cycle.
  // Before the edge: predict the registered outputs and push them to the queue.
  // After the edge: pop the prediction and compare it with the DUT outputs.
  task automatic step(output bit acc);
    exp_t e;
    bit   on;
    bit   blank;
    bit   bound;
    on    = (duty == 3'd7) || (m_cnt < int'(duty) * (SCAN_DIV / 8));
    blank = blank_lz && (m_idx != 0) && ((m_shown >> (4 * m_idx)) == 16'h0);
    e.digit  = (on && !blank) ? 4'(1 << m_idx) : 4'h0;
    e.nibble = m_shown[4*m_idx +: 4];
    bound    = (m_cnt == SCAN_DIV - 1) && (m_idx == NUM_DIGITS - 1);
    e.fs     = bound;
    acc      = load_valid && !m_pfull;
    if (bound && m_pfull) begin
      m_shown = m_pend;
      m_pfull = 1'b0;
    end else if (acc) begin
      m_pend  = load_data;
      m_pfull = 1'b1;
    end
    if (m_cnt == SCAN_DIV - 1) begin
      m_cnt = 0;
      m_idx = (m_idx + 1) % NUM_DIGITS;
    end else begin
      m_cnt++;
    end
    e.ready = !m_pfull;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("digit",       16'(digit),       16'(e.digit));
    chk("nibble",      16'(nibble),      16'(e.nibble));
    chk("frame_start", 16'(frame_start), 16'(e.fs));
    chk("load_ready",  16'(load_ready),  16'(e.ready));
  endtask

  task automatic load(input logic [15:0] v);
    bit acc;
    int n;
    load_valid = 1'b1;
    load_data  = v;
    n          = 0;
    acc        = 1'b0;
    while (!acc && n < 100) begin
      step(acc);
      n++;
    end
    load_valid = 1'b0;
    load_data  = 16'($urandom);
    chk("load_accepted", 16'(acc), 16'd1);
  endtask

  // Step until the DUT shows frame_start. The wait is bounded.
  task automatic wait_frame();
    bit acc;
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 80 && !seen; n++) begin
      step(acc);
      if (frame_start) begin
        seen = 1'b1;
        chk("ready_at_frame_start", 16'(load_ready), 16'd1);
      end
    end
    chk("frame_start_seen", 16'(seen), 16'd1);
  endtask

  // Watch one full frame and count the lit cycles of each digit.
  task automatic observe_frame(input logic [15:0] value, input logic [3:0] mask, input int on);
    bit         acc;
    int         lit [4];
    logic [3:0] nib_seen [4];
    for (int d = 0; d < 4; d++) begin
      lit[d]      = 0;
      nib_seen[d] = 4'h0;
    end
    for (int c = 0; c < 32; c++) begin
      step(acc);
      for (int d = 0; d < 4; d++) begin
        if (digit == 4'(1 << d)) lit[d]++;
      end
      if (c % 8 == 7) nib_seen[c / 8] = nibble;
    end
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("lit_cycles_d%0d", d), 16'(lit[d]), 16'(mask[d] ? on : 0));
      chk($sformatf("slot_nibble_d%0d", d), 16'(nib_seen[d]), 16'(value[4*d +: 4]));
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int fs_cnt;

    vecs[0] = '{16'h1A2F, 1'b0, 3'd7, 4'b1111, 8};
    vecs[1] = '{16'h0050, 1'b1, 3'd7, 4'b0011, 8};
    vecs[2] = '{16'h0000, 1'b1, 3'd7, 4'b0001, 8};
    vecs[3] = '{16'h0000, 1'b0, 3'd3, 4'b1111, 3};
    vecs[4] = '{16'hBEEF, 1'b1, 3'd0, 4'b0000, 0};
    vecs[5] = '{16'h0400, 1'b1, 3'd5, 4'b0111, 5};
    vecs[6] = '{16'h9000, 1'b1, 3'd7, 4'b1111, 8};
    vecs[7] = '{16'h0001, 1'b1, 3'd7, 4'b0001, 8};

    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0;
    blank_lz   = 1'b0;
    duty       = 3'd7;
    #12;
    chk("reset_digit",  16'(digit),       16'h0);
    chk("reset_nibble", 16'(nibble),      16'h0);
    chk("reset_fs",     16'(frame_start), 16'h0);
    chk("reset_ready",  16'(load_ready),  16'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();

    // Free-running scan with no load: the first slot is digit 0.
    // frame_start pulses once every 32 cycles.
    fs_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      step(acc);
      if (i == 0) chk("first_digit", 16'(digit), 16'h1);
      if (frame_start) fs_cnt++;
    end
    chk("fs_pulses_64cyc", 16'(fs_cnt), 16'd2);

    // Load mid-frame. The value stays hidden until the next frame boundary.
    for (int i = 0; i < 5; i++) step(acc);
    load(16'h1A2F);
    chk("ready_drop", 16'(load_ready), 16'h0);
    wait_frame();
    observe_frame(16'h1A2F, 4'b1111, 8);

    // Table of value / blanking / brightness combinations.
    for (int v = 0; v < 8; v++) begin
      duty     = vecs[v].duty;
      blank_lz = vecs[v].blank;
      load(vecs[v].value);
      wait_frame();
      observe_frame(vecs[v].value, vecs[v].mask, vecs[v].on);
    end

    // Back-to-back loads. The second load is held until the first commits.
    duty     = 3'd7;
    blank_lz = 1'b0;
    for (int i = 0; i < 3; i++) step(acc);
    load(16'h1111);
    load(16'h2222);
    chk("b2b_ready_low", 16'(load_ready), 16'h0);
    chk("b2b_first_shown", 16'(nibble), 16'h1);
    wait_frame();
    observe_frame(16'h2222, 4'b1111, 8);

    // Reset in the middle of a slot while a load is pending.
    for (int i = 0; i < 10; i++) step(acc);
    load(16'h7777);
    for (int i = 0; i < 3; i++) step(acc);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_digit",  16'(digit),       16'h0);
    chk("async_rst_nibble", 16'(nibble),      16'h0);
    chk("async_rst_fs",     16'(frame_start), 16'h0);
    chk("async_rst_ready",  16'(load_ready),  16'h1);
    @(posedge clk);
    #1;
    chk("held_rst_digit", 16'(digit), 16'h0);
    rst_n = 1'b1;
    model_reset();
    observe_frame(16'h0000, 4'b1111, 8);
    chk("post_rst_ready", 16'(load_ready), 16'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
